// File: rtl/alu_issue_unit.sv
// alu_issue_unit: buffers ALU instructions in a small FIFO, issues them one at a
// time on registered ALU inputs, captures the result a cycle later, and holds it
// for a downstream valid/ready handshake. An accumulator keeps the last result
// so an instruction can chain it in as operand b.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | nothing in flight; pops the FIFO head as soon as one exists
// EXEC  | ALU inputs stable; result captured at the closing edge
// DONE  | result held on out_*; on handshake pop the next or go IDLE
module alu_issue_unit #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [4:0] in_b,
  input  logic [2:0] in_cmd,
  input  logic       in_chain,
  output logic [3:0] alu_a,
  output logic [4:0] alu_b,
  output logic [2:0] alu_cmd,
  input  logic [4:0] alu_sum,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_res,
  output logic [2:0] out_cmd,
  output logic       busy,
  output logic [7:0] res_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] a;
    logic [4:0] b;
    logic [2:0] cmd;
    logic       chain;
  } entry_t;

  entry_t           fifo_mem_q [DEPTH];
  entry_t           fifo_mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  state_e     state_q, state_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [4:0] alu_b_q, alu_b_d;
  logic [2:0] alu_cmd_q, alu_cmd_d;
  logic       out_valid_q, out_valid_d;
  logic [4:0] out_res_q, out_res_d;
  logic [2:0] out_cmd_q, out_cmd_d;
  logic [4:0] acc_q, acc_d;
  logic [7:0] res_count_q, res_count_d;

  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  entry_t head;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  // A push is judged against the current fill level only, so a full FIFO
  // refuses even when the FSM pops in the same cycle.
  assign push  = in_valid && !full;
  assign head  = fifo_mem_q[rd_ptr_q];

  // Sequencer next-state: decides when to pop and what the ALU/result regs load.
  always_comb begin
    pop         = 1'b0;
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cmd_d   = alu_cmd_q;
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_cmd_d   = out_cmd_q;
    acc_d       = acc_q;
    res_count_d = res_count_q;

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        out_res_d   = alu_sum;
        acc_d       = alu_sum;
        out_cmd_d   = alu_cmd_q;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          res_count_d = res_count_q + 8'd1;
          if (!empty) begin
            pop     = 1'b1;
            state_d = ST_EXEC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Chaining reads acc_q, i.e. the result captured before this pop edge.
    if (pop) begin
      alu_a_d   = head.a;
      alu_b_d   = head.chain ? acc_q : head.b;
      alu_cmd_d = head.cmd;
    end
  end

  // FIFO next-state: storage write, pointer advance and fill count.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (push) begin
      fifo_mem_d[wr_ptr_q] = {in_a, in_b, in_cmd, in_chain};
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cmd_q   <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_cmd_q   <= '0;
      acc_q       <= '0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cmd_q   <= alu_cmd_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_cmd_q   <= out_cmd_d;
      acc_q       <= acc_d;
      res_count_q <= res_count_d;
    end
  end

  assign in_ready  = !full;
  assign busy      = (state_q != ST_IDLE) || !empty;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cmd   = alu_cmd_q;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_cmd   = out_cmd_q;
  assign res_count = res_count_q;

endmodule
